mem_arbiter: RTL and testbench

//  Shares the single RAM port between instruction fetch (iREN) and data access (dREN/dWEN).

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM handshake types plus the memory arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access, data first.
// Optional fetch anti-starvation is built when MEM_ARB_STARVE_EN is defined.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int RETRY_MAX  = 3,
  parameter int STARVE_LIM = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       err,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output arb_state_t dbg_state
);

  // Handshake: a requester holds its REN/WEN high until its wait line reads 0;
  // wait=0 is a one-cycle completion strobe and the load data is valid only then.
  localparam int CNT_MAX = (RETRY_MAX > STARVE_LIM) ? RETRY_MAX : STARVE_LIM;
  localparam int CW      = $clog2(CNT_MAX + 2);

  arb_state_t    state_q, state_d;
  word_t         addr_q, addr_d;
  word_t         store_q, store_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] retry_q, retry_d;
  logic          owner_req;
  logic          done;
  logic          arb;
  logic          force_i;
`ifdef MEM_ARB_STARVE_EN
  logic [CW-1:0] starve_q, starve_d, starve_cur;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wen_q    <= 1'b0;
      retry_q  <= '0;
`ifdef MEM_ARB_STARVE_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wen_q    <= wen_d;
      retry_q  <= retry_d;
`ifdef MEM_ARB_STARVE_EN
      starve_q <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wen_d     = wen_q;
    retry_d   = retry_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    err       = 1'b0;
    done      = 1'b0;
    arb       = 1'b0;
    force_i   = 1'b0;
    owner_req = (state_q == DACC) ? (dREN | dWEN) : iREN;

    // A RAM completion is honoured even if the owner drops its request that cycle.
    case (state_q)
      IDLE: arb = 1'b1;
      IACC, DACC: begin
        if (ramstate == ACCESS || (ramstate == ERROR && retry_q == CW'(RETRY_MAX))) begin
          done    = 1'b1;
          arb     = 1'b1;
          err     = (ramstate == ERROR);
          retry_d = '0;
          if (state_q == IACC) iwait = 1'b0;
          else                 dwait = 1'b0;
        end else if (!owner_req) begin
          state_d = IDLE;
          retry_d = '0;
        end else if (ramstate == ERROR) begin
          retry_d = retry_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_ARB_STARVE_EN
    starve_cur = starve_q;
    if (done && state_q == DACC && iREN && starve_q < CW'(STARVE_LIM))
      starve_cur = starve_q + CW'(1);
    starve_d = starve_cur;
    force_i  = iREN && (starve_cur == CW'(STARVE_LIM));
`endif

    if (arb) begin
      if ((dREN | dWEN) && !force_i) begin
        state_d = DACC;
        addr_d  = daddr;
        store_d = dstore;
        wen_d   = dWEN;
      end else if (iREN) begin
        state_d = IACC;
        addr_d  = iaddr;
        wen_d   = 1'b0;
`ifdef MEM_ARB_STARVE_EN
        starve_d = '0;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign ramREN    = (state_q != IDLE) && !wen_q;
  assign ramWEN    = (state_q == DACC) && wen_q;
  assign ramaddr   = addr_q;
  assign ramstore  = store_q;
  assign iload     = ramload;
  assign dload     = ramload;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Define MEM_ARB_STARVE_EN to also exercise the forced-fetch behaviour.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int RETRY_MAX  = 3;
  localparam int STARVE_LIM = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       iREN = 1'b0;
  word_t      iaddr = '0;
  logic       iwait;
  word_t      iload;
  logic       dREN = 1'b0;
  logic       dWEN = 1'b0;
  word_t      daddr = '0;
  word_t      dstore = '0;
  logic       dwait;
  word_t      dload;
  logic       err;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload = '0;
  ramstate_t  ramstate = FREE;
  arb_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.RETRY_MAX(RETRY_MAX), .STARVE_LIM(STARVE_LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .err(err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: one outstanding transaction record
  bit    m_busy = 1'b0;
  bit    m_data = 1'b0;
  bit    m_wr = 1'b0;
  word_t m_addr = '0;
  word_t m_store = '0;
  int    m_errs = 0;
  int    m_streak = 0;

  function automatic bit model_done();
    return m_busy && (ramstate == ACCESS ||
                      (ramstate == ERROR && (m_errs + 1) > RETRY_MAX));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy = 1'b0; m_data = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_store = '0; m_errs = 0; m_streak = 0;
    end else begin
      bit fin, want_data, forced;
      fin = model_done();
      if (!m_busy || fin) begin
        if (fin && m_data && iREN && m_streak < STARVE_LIM) m_streak++;
        forced    = STARVE_ON && iREN && (m_streak >= STARVE_LIM);
        want_data = (dREN || dWEN) && !forced;
        m_errs    = 0;
        if (want_data) begin
          m_busy = 1'b1; m_data = 1'b1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
        end else if (iREN) begin
          m_busy = 1'b1; m_data = 1'b0; m_wr = 1'b0; m_addr = iaddr; m_streak = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (!(m_data ? (dREN || dWEN) : iREN)) begin
        m_busy = 1'b0;
        m_errs = 0;
      end else if (ramstate == ERROR) begin
        m_errs++;
      end
    end
  end

  // scoreboard compare every cycle
  always @(negedge CLK) begin
    bit fin;
    arb_state_t exp_st;
    fin    = model_done();
    exp_st = !m_busy ? IDLE : (m_data ? DACC : IACC);
    chk("ramREN", ramREN, m_busy && !m_wr);
    chk("ramWEN", ramWEN, m_busy && m_wr);
    chk("ramaddr", ramaddr, m_addr);
    chk("ramstore", ramstore, m_store);
    chk("iwait", iwait, !(fin && !m_data));
    chk("dwait", dwait, !(fin && m_data));
    chk("err", err, fin && ramstate == ERROR);
    chk("iload", iload, ramload);
    chk("dload", dload, ramload);
    chk("state", 32'(dbg_state), 32'(exp_st));
  end

  // driver tasks
  task automatic next_cyc();
    @(posedge CLK); #1;
  endtask

  task automatic at_mid();
    @(negedge CLK); #1;
  endtask

  initial begin
    repeat (2) next_cyc();
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_iwait", iwait, 1'b1);
    chk("rst_ramaddr", ramaddr, 32'h0);
    nRST = 1'b1;
    next_cyc();

    // instruction fetch with two BUSY cycles
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    next_cyc();
    at_mid(); chk("t2_addr1", ramaddr, 32'h40); chk("t2_iwait1", iwait, 1'b1);
    next_cyc();
    at_mid(); chk("t2_addr2", ramaddr, 32'h40); chk("t2_ren2", ramREN, 1'b1);
    next_cyc();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    at_mid(); chk("t2_addr3", ramaddr, 32'h40); chk("t2_iwait3", iwait, 1'b0);
    chk("t2_iload3", iload, 32'hDEADBEEF);
    #2 iREN = 1'b0;
    next_cyc();
    ramstate = FREE;
    at_mid(); chk("t2_idle_ren", ramREN, 1'b0);
    next_cyc();

    // simultaneous data write and fetch: write wins, fetch follows directly
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; dWEN = 1'b1;
    daddr = 32'h100; dstore = 32'h5; ramstate = BUSY;
    next_cyc();
    ramstate = ACCESS;
    at_mid(); chk("t3_wen", ramWEN, 1'b1); chk("t3_ren", ramREN, 1'b0);
    chk("t3_store", ramstore, 32'h5); chk("t3_addr", ramaddr, 32'h100);
    chk("t3_dwait", dwait, 1'b0); chk("t3_iwait", iwait, 1'b1);
    #2 dREN = 1'b0; dWEN = 1'b0;
    next_cyc();
    ramstate = BUSY;
    at_mid(); chk("t3_iacc_addr", ramaddr, 32'h80); chk("t3_iacc_ren", ramREN, 1'b1);
    chk("t3_iacc_st", 32'(dbg_state), 32'(IACC));
    next_cyc();
    ramstate = ACCESS; ramload = 32'h12345678;
    at_mid(); chk("t3_iwait", iwait, 1'b0); chk("t3_iload", iload, 32'h12345678);
    #2 iREN = 1'b0;
    next_cyc();
    ramstate = FREE;
    next_cyc();

    // bounded retries, then a fresh transaction proves the counter cleared
    dREN = 1'b1; daddr = 32'h200; ramstate = ERROR;
    next_cyc();
    for (int k = 1; k <= 4; k++) begin
      at_mid();
      chk("t4_dwait", dwait, (k == 4) ? 1'b0 : 1'b1);
      chk("t4_err", err, (k == 4) ? 1'b1 : 1'b0);
      if (k == 4) begin #2 dREN = 1'b0; end
      next_cyc();
    end
    ramstate = FREE;
    next_cyc();
    dREN = 1'b1; daddr = 32'h204; ramstate = ERROR;
    next_cyc();
    for (int k = 1; k <= 3; k++) begin
      at_mid(); chk("t4b_dwait", dwait, 1'b1);
      next_cyc();
    end
    ramstate = ACCESS;
    at_mid(); chk("t4b_dwait_done", dwait, 1'b0); chk("t4b_err", err, 1'b0);
    #2 dREN = 1'b0;
    next_cyc();
    ramstate = FREE;
    next_cyc();

    // abort after one BUSY cycle
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    next_cyc();
    at_mid(); chk("t5_ren1", ramREN, 1'b1); chk("t5_dwait1", dwait, 1'b1);
    next_cyc();
    dREN = 1'b0;
    at_mid(); chk("t5_dwait2", dwait, 1'b1);
    next_cyc();
    at_mid(); chk("t5_ren3", ramREN, 1'b0); chk("t5_st3", 32'(dbg_state), 32'(IDLE));
    ramstate = FREE;
    next_cyc();

    // async reset in the middle of a data write
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'hAA; ramstate = BUSY;
    next_cyc();
    at_mid(); chk("t1_wen_before", ramWEN, 1'b1);
    nRST = 1'b0;
    #1;
    chk("t1_ren", ramREN, 1'b0); chk("t1_wen", ramWEN, 1'b0);
    chk("t1_dwait", dwait, 1'b1); chk("t1_iwait", iwait, 1'b1);
    chk("t1_addr", ramaddr, 32'h0); chk("t1_store", ramstore, 32'h0);
    chk("t1_err", err, 1'b0);
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    next_cyc();
    nRST = 1'b1;
    next_cyc();

    // both requesters held with RAM answering every cycle
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600; ramstate = ACCESS;
    next_cyc();
    for (int k = 0; k < 10; k++) begin
      bit fetch;
      fetch = STARVE_ON && (k % 5 == 4);
      at_mid();
      chk("t6_dwait", dwait, fetch ? 1'b1 : 1'b0);
      chk("t6_iwait", iwait, fetch ? 1'b0 : 1'b1);
      if (k == 9) begin #2 dREN = 1'b0; iREN = 1'b0; end
      next_cyc();
    end
    ramstate = FREE;
    repeat (2) next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
